xmss_apb_bridge: RTL
====================

XMSS_APB_BRIDGE -- requirements
Module: xmss_apb_bridge

Interface
REQ-001 Parameter WOTS_W, default 16, Winternitz width; WOTS_LOG_W = clog2(WOTS_W), default 4.
REQ-002 io_mainClk  in  1  sole clock, rising edge.
REQ-003 io_systemReset  in  1  reset, asynchronous, active-high.
REQ-004 PSEL, PENABLE, PWRITE  in  1 each  APB3 slave controls.
REQ-005 PADDR  in  8  byte address, bits [1:0] ignored.
REQ-006 PWDATA  in  32  write data.
REQ-007 PRDATA  out  32  read data.
REQ-008 PREADY  out  1  transfer complete.
REQ-009 PSLVERROR  out  1  transfer error.
REQ-010 cmd_reg  out  3  command code: 001 sha256, 010 sha256XMSS, 011 gen_chain, 100 gen_leaf.
REQ-011 input_data_reg  out  1024  operand block.
REQ-012 gen_leaf_start_reg, gen_chain_start_reg, sha256XMSS_sha256XMSS_start_reg, sha256_sha256_start_reg  out  1 each  start pulses.
REQ-013 gen_leaf_reset  out  1  leaf-engine reset pulse.
REQ-014 gen_chain_start_step_reg, gen_chain_end_step_reg  out  WOTS_LOG_W each  chain step bounds.
REQ-015 sha256XMSS_sha256XMSS_{second_block_data_available, store_intermediate, continue_intermediate, init_iv, message_length}, sha256_sha256_init_message, sha256_sha256_init_iv  out  1 each  level flags from CTRL.
REQ-016 output_data  in  256  result from the engine side.
REQ-017 module_busy  in  1  engine busy.

Function
REQ-018 Map: 0x00 CTRL (RW), 0x04 STATUS (RO), 0x08 STEP (RW: [3:0] start, [7:4] end), 0x40+4j DATA_OUT word j (j=0..7, RO, bits [32j+31:32j]), 0x80+4i DATA_IN word i (i=0..31, RW, bits [32i+31:32i]).
REQ-019 CTRL: [2:0] cmd, [3] START (write-1 pulse, reads 0), [4] LEAF_RST (write-1 pulse, reads 0), [11:5] level flags in REQ-015 order, [12] IRQ_EN.
REQ-020 STATUS: [0] busy (FSM not IDLE), [1] done (sticky), [2] err (sticky); STATUS read clears done and err after returning them.
REQ-021 PREADY is tied to 1; all transfers complete in the APB access phase with zero wait states.
REQ-022 Unmapped address, write to RO register, or DATA_IN/STEP/CTRL.cmd write while not IDLE -> no register change, PSLVERROR=1 in that access phase, err set; erroring reads return 0.
REQ-023 FSM states IDLE, FIRE, WAIT, RUN.
REQ-024 IDLE: CTRL write with START=1 -> FIRE; START write outside IDLE ignored, PSLVERROR=1, err set.
REQ-025 FIRE (exactly 1 cycle): the start pulse selected by cmd is 1, others 0; cmd 000/101-111 fires nothing, sets err, returns to IDLE; otherwise -> WAIT.
REQ-026 WAIT: module_busy=1 -> RUN; 4 cycles without busy -> capture.
REQ-027 RUN: module_busy=0 -> capture.
REQ-028 Capture: output_data latched into DATA_OUT snapshot, done set, -> IDLE in the same cycle.
REQ-029 LEAF_RST write: gen_leaf_reset high exactly 1 cycle; FSM forced to IDLE, no capture, done unchanged.
REQ-030 Simultaneous capture and STATUS read: the read returns the old done, and done=1 afterwards (set wins over clear).

Reset
REQ-031 io_systemReset clears every register: outputs 0, cmd_reg 000, PRDATA 0, PSLVERROR 0, STEP 0, DATA_IN 0, DATA_OUT 0, STATUS 0, FSM IDLE.
REQ-032 Reset mid-operation aborts without capture; start pulses are never truncated into glitches.

Configuration
REQ-033 Macro XMSS_BRIDGE_IRQ_EN defined: port irq (out, 1) = done & IRQ_EN, registered.
REQ-034 Macro XMSS_BRIDGE_IRQ_EN undefined: no irq port; CTRL[12] reads 0, writes ignored.

Structure
REQ-035 Package xmss_bridge_pkg holds the address offsets, CTRL/STATUS bit positions, cmd codes, FSM state enum and WAIT timeout constant (4).
REQ-036 Sub-module xmss_cmd_seq holds the FSM, start-pulse decode and capture strobe; the top holds APB decode and the registers.

Verification
REQ-037 Write DATA_IN word 31 = 0xDEADBEEF -> input_data_reg[1023:992]=0xDEADBEEF, PSLVERROR=0.
REQ-038 CTRL=0x0C (cmd 100, START) with module_busy high for 10 cycles, output_data=0x...A5 -> gen_leaf_start_reg high 1 cycle, STATUS=0x1 during the run, then 0x2; DATA_OUT word 0 reads 0x000000A5; the next STATUS read returns 0.
REQ-039 Second START during RUN, or DATA_IN write during RUN -> PSLVERROR=1, operand unchanged, err=1.
REQ-040 CTRL=0x08 (cmd 000) -> no start pulse, err=1, FSM IDLE after 2 cycles; read 0x0C -> PSLVERROR=1, PRDATA 0.
REQ-041 cmd 001 START with module_busy never high -> done after FIRE plus 4 WAIT cycles; LEAF_RST during RUN -> 1-cycle gen_leaf_reset, IDLE, done 0.
REQ-042 With XMSS_BRIDGE_IRQ_EN, IRQ_EN=1: irq rises the cycle after done is set and falls the cycle after the STATUS read.

Source files
------------

// File: rtl/xmss_bridge_pkg.sv
// Shared constants for the XMSS APB bridge: register map, bit fields,
// command codes, sequencer states and the no-busy timeout.
package xmss_bridge_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_STEP   = 8'h08;
  localparam logic [7:0] ADDR_DOUT   = 8'h40;
  localparam logic [7:0] ADDR_DIN    = 8'h80;

  localparam int CTRL_CMD_LSB  = 0;
  localparam int CTRL_START    = 3;
  localparam int CTRL_LEAF_RST = 4;
  localparam int CTRL_FLAG_LSB = 5;
  localparam int CTRL_FLAG_W   = 7;
  localparam int CTRL_IRQ_EN   = 12;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int STEP_START_LSB = 0;
  localparam int STEP_END_LSB   = 4;

  localparam logic [2:0] CMD_SHA256 = 3'b001;
  localparam logic [2:0] CMD_XMSS   = 3'b010;
  localparam logic [2:0] CMD_CHAIN  = 3'b011;
  localparam logic [2:0] CMD_LEAF   = 3'b100;

  localparam int WAIT_CYCLES = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_RUN
  } seq_state_e;

  function automatic logic cmd_valid(input logic [2:0] c);
    return c inside {CMD_SHA256, CMD_XMSS, CMD_CHAIN, CMD_LEAF};
  endfunction

endpackage

// File: rtl/xmss_apb_bridge_if.sv
// APB3 slave bus bundle for the XMSS bridge.
// master drives PSEL/PENABLE/PWRITE/PADDR/PWDATA; slave returns PRDATA/PREADY/PSLVERROR.
interface xmss_apb_bridge_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERROR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERROR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERROR
  );
endinterface

// File: rtl/xmss_cmd_seq.sv
// Command sequencer: IDLE/FIRE/WAIT/RUN FSM, start-pulse decode, capture strobe.
// In: go, abort, cmd, module_busy. Out: idle, capture, cmd_err, four start pulses.
module xmss_cmd_seq
  import xmss_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       abort,
  input  logic [2:0] cmd,
  input  logic       module_busy,
  output logic       idle,
  output logic       capture,
  output logic       cmd_err,
  output logic       sha256_start,
  output logic       xmss_start,
  output logic       chain_start,
  output logic       leaf_start
);

  localparam int CW = $clog2(WAIT_CYCLES);

  seq_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    cmd_err = 1'b0;
    unique case (state_q)
      S_IDLE: if (go) state_d = S_FIRE;
      S_FIRE: begin
        cnt_d = '0;
        if (cmd_valid(cmd)) begin
          state_d = S_WAIT;
        end else begin
          cmd_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (module_busy) begin
          state_d = S_RUN;
        end else if (cnt_q == CW'(WAIT_CYCLES - 1)) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!module_busy) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Leaf reset abandons whatever is in flight without a result.
    if (abort) begin
      state_d = S_IDLE;
      capture = 1'b0;
      cmd_err = 1'b0;
    end
  end

  // cmd cannot change outside IDLE, so these decode cleanly off FIRE.
  always_comb begin
    sha256_start = 1'b0;
    xmss_start   = 1'b0;
    chain_start  = 1'b0;
    leaf_start   = 1'b0;
    if (state_q == S_FIRE) begin
      unique case (1'b1)
        cmd == CMD_SHA256: sha256_start = 1'b1;
        cmd == CMD_XMSS:   xmss_start   = 1'b1;
        cmd == CMD_CHAIN:  chain_start  = 1'b1;
        cmd == CMD_LEAF:   leaf_start   = 1'b1;
        default: ;
      endcase
    end
  end

  assign idle = (state_q == S_IDLE);

endmodule

// File: rtl/xmss_apb_bridge.sv
// APB3 register bridge to the XMSS hash engines: decode, registers, status.
// Ports: io_mainClk, io_systemReset, apb (slave), engine controls/operands,
// output_data, module_busy; irq only when XMSS_BRIDGE_IRQ_EN is defined.
module xmss_apb_bridge
  import xmss_bridge_pkg::*;
#(
  parameter int WOTS_W     = 16,
  parameter int WOTS_LOG_W = $clog2(WOTS_W)
) (
  input  logic                  io_mainClk,
  input  logic                  io_systemReset,
  xmss_apb_bridge_if.slave      apb,
  output logic [2:0]            cmd_reg,
  output logic [1023:0]         input_data_reg,
  output logic                  gen_leaf_start_reg,
  output logic                  gen_chain_start_reg,
  output logic                  sha256XMSS_sha256XMSS_start_reg,
  output logic                  sha256_sha256_start_reg,
  output logic                  gen_leaf_reset,
  output logic [WOTS_LOG_W-1:0] gen_chain_start_step_reg,
  output logic [WOTS_LOG_W-1:0] gen_chain_end_step_reg,
  output logic                  sha256XMSS_sha256XMSS_second_block_data_available,
  output logic                  sha256XMSS_sha256XMSS_store_intermediate,
  output logic                  sha256XMSS_sha256XMSS_continue_intermediate,
  output logic                  sha256XMSS_sha256XMSS_init_iv,
  output logic                  sha256XMSS_sha256XMSS_message_length,
  output logic                  sha256_sha256_init_message,
  output logic                  sha256_sha256_init_iv,
  input  logic [255:0]          output_data,
  input  logic                  module_busy
`ifdef XMSS_BRIDGE_IRQ_EN
  ,
  output logic                  irq
`endif
);

  logic [2:0]             cmd_q;
  logic [CTRL_FLAG_W-1:0] flags_q;
  logic                   irq_en_q;
  logic [WOTS_LOG_W-1:0]  step_s_q, step_e_q;
  logic [1023:0]          din_q;
  logic [255:0]           dout_q;
  logic                   done_q, err_q, lrst_q;

  logic idle, capture, cmd_err;
  logic access, wr, is_ctrl, is_stat, is_step, is_dout, is_din;
  logic ctrl_bad, bad, wr_ok, stat_rd, go, abort;
  logic [31:0] rdata;
  logic [1:0] unused_addr;

  assign unused_addr = apb.PADDR[1:0];

  assign access  = apb.PSEL & apb.PENABLE;
  assign wr      = apb.PWRITE;
  assign is_ctrl = apb.PADDR[7:2] == ADDR_CTRL[7:2];
  assign is_stat = apb.PADDR[7:2] == ADDR_STATUS[7:2];
  assign is_step = apb.PADDR[7:2] == ADDR_STEP[7:2];
  assign is_dout = apb.PADDR[7:5] == ADDR_DOUT[7:5];
  assign is_din  = apb.PADDR[7] == ADDR_DIN[7];

  // Outside IDLE, CTRL may only touch flags / LEAF_RST with cmd held.
  assign ctrl_bad = !idle &&
    (apb.PWDATA[CTRL_START] || apb.PWDATA[2:0] != cmd_q);

  assign bad = !(is_ctrl | is_stat | is_step | is_dout | is_din)
             | (wr & (is_stat | is_dout))
             | (wr & (is_din | is_step) & !idle)
             | (wr & is_ctrl & ctrl_bad);

  assign wr_ok   = access & wr & !bad;
  assign stat_rd = access & !wr & is_stat;
  assign go      = wr_ok & is_ctrl & apb.PWDATA[CTRL_START];
  assign abort   = wr_ok & is_ctrl & apb.PWDATA[CTRL_LEAF_RST];

  always_comb begin
    rdata = '0;
    if (access && !wr && !bad) begin
      unique case (1'b1)
        is_ctrl: begin
          rdata[2:0] = cmd_q;
          rdata[CTRL_FLAG_LSB +: CTRL_FLAG_W] = flags_q;
          rdata[CTRL_IRQ_EN] = irq_en_q;
        end
        is_stat: begin
          rdata[STAT_BUSY] = !idle;
          rdata[STAT_DONE] = done_q;
          rdata[STAT_ERR]  = err_q;
        end
        is_step: begin
          rdata[STEP_START_LSB +: WOTS_LOG_W] = step_s_q;
          rdata[STEP_END_LSB +: WOTS_LOG_W]   = step_e_q;
        end
        is_dout: rdata = dout_q[{apb.PADDR[4:2], 5'd0} +: 32];
        is_din:  rdata = din_q[{apb.PADDR[6:2], 5'd0} +: 32];
        default: rdata = '0;
      endcase
    end
  end

  assign apb.PRDATA    = rdata;
  assign apb.PREADY    = 1'b1;
  assign apb.PSLVERROR = access & bad;

  always_ff @(posedge io_mainClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      cmd_q    <= '0;
      flags_q  <= '0;
      step_s_q <= '0;
      step_e_q <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      lrst_q   <= 1'b0;
`ifdef XMSS_BRIDGE_IRQ_EN
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
`endif
    end else begin
      lrst_q <= abort;
      if (wr_ok && is_ctrl) begin
        cmd_q   <= apb.PWDATA[2:0];
        flags_q <= apb.PWDATA[CTRL_FLAG_LSB +: CTRL_FLAG_W];
`ifdef XMSS_BRIDGE_IRQ_EN
        irq_en_q <= apb.PWDATA[CTRL_IRQ_EN];
`endif
      end
      if (wr_ok && is_step) begin
        step_s_q <= apb.PWDATA[STEP_START_LSB +: WOTS_LOG_W];
        step_e_q <= apb.PWDATA[STEP_END_LSB +: WOTS_LOG_W];
      end
      if (wr_ok && is_din)
        din_q[{apb.PADDR[6:2], 5'd0} +: 32] <= apb.PWDATA;
      if (capture)
        dout_q <= output_data;
      // A capture coinciding with the STATUS read keeps done set.
      done_q <= capture | (done_q & !stat_rd);
      err_q  <= (access & bad) | cmd_err | (err_q & !stat_rd);
`ifdef XMSS_BRIDGE_IRQ_EN
      irq <= done_q & irq_en_q;
`endif
    end
  end

`ifndef XMSS_BRIDGE_IRQ_EN
  assign irq_en_q = 1'b0;
`endif

  xmss_cmd_seq u_seq (
    .clk          (io_mainClk),
    .rst          (io_systemReset),
    .go           (go),
    .abort        (abort),
    .cmd          (cmd_q),
    .module_busy  (module_busy),
    .idle         (idle),
    .capture      (capture),
    .cmd_err      (cmd_err),
    .sha256_start (sha256_sha256_start_reg),
    .xmss_start   (sha256XMSS_sha256XMSS_start_reg),
    .chain_start  (gen_chain_start_reg),
    .leaf_start   (gen_leaf_start_reg)
  );

  assign cmd_reg                  = cmd_q;
  assign input_data_reg           = din_q;
  assign gen_leaf_reset           = lrst_q;
  assign gen_chain_start_step_reg = step_s_q;
  assign gen_chain_end_step_reg   = step_e_q;

  assign sha256XMSS_sha256XMSS_second_block_data_available = flags_q[0];
  assign sha256XMSS_sha256XMSS_store_intermediate          = flags_q[1];
  assign sha256XMSS_sha256XMSS_continue_intermediate       = flags_q[2];
  assign sha256XMSS_sha256XMSS_init_iv                     = flags_q[3];
  assign sha256XMSS_sha256XMSS_message_length              = flags_q[4];
  assign sha256_sha256_init_message                        = flags_q[5];
  assign sha256_sha256_init_iv                             = flags_q[6];

endmodule
